inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
- Converts decoded instruction fields (kind, rd, rs1, rs2, full 32-bit immediate) into 32-bit RV32I machine words for ADDI, SRAI, LW, SW and BEQ. It is the inverse of the core's immediate generation.
- Used by the test-program loader to stream encoded words, with target addresses, into instruction memory.
- Valid/ready on both sides, with a 2-entry output buffer. Immediate range is checked; an illegal request becomes a NOP and raises an error.

Parameters:
- BASE_ADDR, 32'h0000_0000, address attached to the first emitted word after reset
- ADDR_STEP, 4, address increment per emitted word

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset; asynchronous, active-high
- valid_i  input  1  request valid
- ready_o  output  1  request accepted when valid_i && ready_o
- kind_i  input  3  0=ADDI 1=SRAI 2=LW 3=SW 4=BEQ; 5-7 illegal
- rd_i  input  5  destination register
- rs1_i  input  5  source register 1
- rs2_i  input  5  source register 2 (SW, BEQ only)
- imm_i  input  32  signed immediate; byte offset for BEQ
- valid_o  output  1  encoded word available
- ready_i  input  1  consumer accepts when valid_o && ready_i
- inst_o  output  32  encoded instruction
- addr_o  output  32  memory address for inst_o
- err_o  output  1  sticky: set by any illegal request, cleared only by reset
- err_cnt_o  output  8  saturating count of illegal requests

Behaviour:
- Reset (asynchronous, active-high):
  - buffer emptied; valid_o=0, ready_o=1
  - inst_o=0, addr_o=BASE_ADDR, err_o=0, err_cnt_o=0
  - a reset mid-stream discards all buffered words.
- Buffer: 2-entry FIFO with read/write pointers and a count; ready_o = (count<2).
- Latency: a word accepted in cycle N is visible on inst_o in cycle N+1 if the buffer was empty. No combinational path from valid_i to valid_o.
- Simultaneous push and pop when count=2: ready_o=0, so no push occurs; the pop frees a slot for the next cycle.
- Push and pop in the same cycle at count=1: count stays 1, order preserved.
- Output stability: while valid_o=1 and ready_i=0, inst_o and addr_o hold stable.
- Address counter:
  - addr_o is the address of the head word.
  - Increments by ADDR_STEP on each output handshake; wraps modulo 2^32.
  - NOP substitutes also consume an address.
- Encodings:
  - ADDI: imm[11:0]|rs1|000|rd|0010011
  - SRAI: 0100000|imm[4:0]|rs1|101|rd|0010011
  - LW: imm[11:0]|rs1|010|rd|0000011
  - SW: imm[11:5]|rs2|rs1|010|imm[4:0]|0100011
  - BEQ: imm[12]|imm[10:5]|rs2|rs1|000|imm[4:1]|imm[11]|1100011
- Range checks (fail = illegal):
  - ADDI/LW/SW: imm_i in [-2048, 2047], i.e. imm_i[31:11] all equal.
  - SRAI: imm_i[31:5]==0.
  - BEQ: imm_i[0]==0 and imm_i in [-4096, 4094].
  - kind_i 5-7: always illegal.
- Illegal request handling:
  - Word replaced by NOP 32'h0000_0013; still pushed and emitted.
  - err_o set and err_cnt_o incremented (saturates at 255) in the accept cycle.
- Unused register fields are ignored: rd for SW/BEQ, rs2 for I-type.

Optional Feature:
- INST_ENCODER_ROUNDTRIP_CHECK_EN
- Defined:
  - Each word is decoded back to its immediate, sign-extended to 32 bits; BEQ is reconstructed as a byte offset.
  - A mismatch against the accepted imm_i (legal requests only) sets a sticky output chk_err_o.
  - The check is registered one cycle after accept.
- Undefined: chk_err_o port and checker logic absent; rest of behaviour identical.

Decomposition:
- Package inst_encoder_pkg:
  - kind codes (KIND_ADDI..KIND_BEQ)
  - opcodes OPC_OPIMM=7'b0010011, OPC_LOAD=7'b0000011, OPC_STORE=7'b0100011, OPC_BRANCH=7'b1100011
  - funct3 values, FUNCT7_SRA=7'b0100000
  - NOP_WORD=32'h0000_0013
- Sub-module inst_pack: combinational kind/fields/imm to {word, illegal}. inst_encoder holds FIFO, address counter, error state.

Test Plan:
- ADDI rd=1 rs1=0 imm=5, ready_i=1 -> next cycle inst_o=32'h0050_0093, addr_o=BASE_ADDR, err_o=0.
- SW rs2=2 rs1=0 imm=8, then BEQ rs1=1 rs2=2 imm=-4, then SRAI rd=3 rs1=3 imm=2:
  - inst_o = 32'h0020_2423, 32'hFE20_8EE3, 32'h4021_D193
  - addr_o = 0, 4, 8
- ADDI imm=4096, then BEQ imm=3 -> both emit 32'h0000_0013; err_o=1; err_cnt_o=2.
- ready_i=0, three back-to-back requests:
  - first two accepted; ready_o=0 and the third held.
  - raise ready_i -> all three emitted in order, no loss or duplicate.
  - inst_o stable while stalled.
- Buffer holds 2 words and err_o=1; assert rst_i asynchronously between clock edges -> immediately valid_o=0, ready_o=1, err_o=0, addr_o=BASE_ADDR.
- BASE_ADDR=32'hFFFF_FFFC, two legal words -> addr_o=32'hFFFF_FFFC then 32'h0000_0000.

Source files
------------

// File: rtl/inst_encoder_pkg.sv
// Shared constants for the RV32I instruction encoder.
// Optional INST_ENCODER_ROUNDTRIP_CHECK_EN uses unpack_imm.
package inst_encoder_pkg;

    localparam logic [2:0] KIND_ADDI = 3'd0;
    localparam logic [2:0] KIND_SRAI = 3'd1;
    localparam logic [2:0] KIND_LW   = 3'd2;
    localparam logic [2:0] KIND_SW   = 3'd3;
    localparam logic [2:0] KIND_BEQ  = 3'd4;

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_SRAI = 3'b101;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    localparam logic [6:0]  FUNCT7_SRA = 7'b0100000;
    localparam logic [31:0] NOP_WORD   = 32'h0000_0013;

    // Recovers the sign-extended immediate from an encoded word
    function automatic logic [31:0] unpack_imm(
        input logic [2:0]  kind,
        input logic [31:0] w
    );
        logic [31:0] v;
        v = '0;
        case (kind)
            KIND_ADDI, KIND_LW: v = {{20{w[31]}}, w[31:20]};
            KIND_SRAI:          v = {27'b0, w[24:20]};
            KIND_SW:            v = {{20{w[31]}}, w[31:25], w[11:7]};
            KIND_BEQ:           v = {{19{w[31]}}, w[31], w[7],
                                     w[30:25], w[11:8], 1'b0};
            default:            v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/inst_encoder_pack.sv
// Combinational field packer: kind/regs/imm to RV32I word plus
// an illegal flag; illegal requests collapse to the NOP word.
module inst_pack
    import inst_encoder_pkg::*;
(
    input  logic [2:0]  i_kind,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [31:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_illegal
);

    logic        w_imm12_ok;
    logic        w_sh_ok;
    logic        w_br_ok;
    logic [31:0] w_raw;
    logic        w_bad;

    assign w_imm12_ok = (&i_imm[31:11]) | ~(|i_imm[31:11]);
    assign w_sh_ok    = ~(|i_imm[31:5]);
    assign w_br_ok    = ~i_imm[0] &
                        ((&i_imm[31:12]) | ~(|i_imm[31:12]));

    always_comb begin
        w_raw = NOP_WORD;
        w_bad = 1'b1;
        unique case (i_kind)
            KIND_ADDI: begin
                w_raw = {i_imm[11:0], i_rs1, F3_ADDI, i_rd, OPC_OPIMM};
                w_bad = ~w_imm12_ok;
            end
            KIND_SRAI: begin
                w_raw = {FUNCT7_SRA, i_imm[4:0], i_rs1, F3_SRAI,
                         i_rd, OPC_OPIMM};
                w_bad = ~w_sh_ok;
            end
            KIND_LW: begin
                w_raw = {i_imm[11:0], i_rs1, F3_LW, i_rd, OPC_LOAD};
                w_bad = ~w_imm12_ok;
            end
            KIND_SW: begin
                w_raw = {i_imm[11:5], i_rs2, i_rs1, F3_SW,
                         i_imm[4:0], OPC_STORE};
                w_bad = ~w_imm12_ok;
            end
            KIND_BEQ: begin
                w_raw = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, F3_BEQ,
                         i_imm[4:1], i_imm[11], OPC_BRANCH};
                w_bad = ~w_br_ok;
            end
            default: begin
                w_raw = NOP_WORD;
                w_bad = 1'b1;
            end
        endcase
    end

    assign o_word    = w_bad ? NOP_WORD : w_raw;
    assign o_illegal = w_bad;

endmodule

// File: rtl/inst_encoder.sv
// RV32I encoder with 2-entry output FIFO, address counter, error state.
// Define INST_ENCODER_ROUNDTRIP_CHECK_EN to add the chk_err_o checker.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ADDR_STEP = 32'd4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [2:0]  kind_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] addr_o,
    output logic        err_o,
`ifdef INST_ENCODER_ROUNDTRIP_CHECK_EN
    output logic        chk_err_o,
`endif
    output logic [7:0]  err_cnt_o
);

    logic [31:0] r_mem [2];
    logic        r_wp;
    logic        r_rp;
    logic [1:0]  r_cnt;
    logic [31:0] r_addr;
    logic        r_err;
    logic [7:0]  r_err_cnt;

    logic [31:0] w_word;
    logic        w_illegal;
    logic        w_push;
    logic        w_pop;

    inst_pack u_pack (
        .i_kind    (kind_i),
        .i_rd      (rd_i),
        .i_rs1     (rs1_i),
        .i_rs2     (rs2_i),
        .i_imm     (imm_i),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    assign ready_o = (r_cnt != 2'd2);
    assign valid_o = (r_cnt != 2'd0);
    assign w_push  = valid_i & ready_o;
    assign w_pop   = valid_o & ready_i;

    assign inst_o    = valid_o ? r_mem[r_rp] : 32'h0;
    assign addr_o    = r_addr;
    assign err_o     = r_err;
    assign err_cnt_o = r_err_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mem[0]  <= '0;
            r_mem[1]  <= '0;
            r_wp      <= 1'b0;
            r_rp      <= 1'b0;
            r_cnt     <= 2'd0;
            r_addr    <= BASE_ADDR;
            r_err     <= 1'b0;
            r_err_cnt <= 8'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= w_word;
                r_wp        <= ~r_wp;
            end
            if (w_pop) begin
                r_rp   <= ~r_rp;
                r_addr <= r_addr + ADDR_STEP;
            end
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
            if (w_push && w_illegal) begin
                r_err <= 1'b1;
                if (r_err_cnt != 8'hFF)
                    r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

`ifdef INST_ENCODER_ROUNDTRIP_CHECK_EN
    logic        r_chk_vld;
    logic [2:0]  r_chk_kind;
    logic [31:0] r_chk_word;
    logic [31:0] r_chk_imm;
    logic        r_chk_err;

    assign chk_err_o = r_chk_err;

    // Decode compare runs on the word captured at accept time
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_chk_vld  <= 1'b0;
            r_chk_kind <= '0;
            r_chk_word <= '0;
            r_chk_imm  <= '0;
            r_chk_err  <= 1'b0;
        end else begin
            r_chk_vld <= w_push & ~w_illegal;
            if (w_push) begin
                r_chk_kind <= kind_i;
                r_chk_word <= w_word;
                r_chk_imm  <= imm_i;
            end
            if (r_chk_vld &&
                unpack_imm(r_chk_kind, r_chk_word) != r_chk_imm)
                r_chk_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_encoder.sv
// Directed-vector bench for inst_encoder, two instances
// sharing stimulus to cover default and wrapping BASE_ADDR.
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b1;
    logic [2:0]  kind_i = '0;
    logic [4:0]  rd_i = '0;
    logic [4:0]  rs1_i = '0;
    logic [4:0]  rs2_i = '0;
    logic [31:0] imm_i = '0;

    logic        ready_o, valid_o, err_o;
    logic [31:0] inst_o, addr_o;
    logic [7:0]  err_cnt_o;
    logic        ready2, valid2, err2;
    logic [31:0] inst2, addr2;
    logic [7:0]  cnt2;
`ifdef INST_ENCODER_ROUNDTRIP_CHECK_EN
    logic        chk1, chk2;
`endif

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    inst_encoder dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
        .kind_i(kind_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .imm_i(imm_i), .valid_o(valid_o), .ready_i(ready_i),
        .inst_o(inst_o), .addr_o(addr_o), .err_o(err_o),
`ifdef INST_ENCODER_ROUNDTRIP_CHECK_EN
        .chk_err_o(chk1),
`endif
        .err_cnt_o(err_cnt_o)
    );

    inst_encoder #(.BASE_ADDR(32'hFFFF_FFFC)) dut2 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready2),
        .kind_i(kind_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .imm_i(imm_i), .valid_o(valid2), .ready_i(ready_i),
        .inst_o(inst2), .addr_o(addr2), .err_o(err2),
`ifdef INST_ENCODER_ROUNDTRIP_CHECK_EN
        .chk_err_o(chk2),
`endif
        .err_cnt_o(cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [2:0] k, input logic [4:0] rd,
                         input logic [4:0] r1, input logic [4:0] r2,
                         input logic [31:0] imm);
        valid_i = 1'b1;
        kind_i  = k;
        rd_i    = rd;
        rs1_i   = r1;
        rs2_i   = r2;
        imm_i   = imm;
    endtask

    task automatic do_reset();
        @(negedge clk);
        valid_i = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_valid", {31'b0, valid_o}, 32'd0);
        chk("rst_ready", {31'b0, ready_o}, 32'd1);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_addr", addr_o, 32'h0);
        chk("rst_err", {31'b0, err_o}, 32'd0);
        chk("rst_cnt", {24'b0, err_cnt_o}, 32'd0);
        chk("rst_addr2", addr2, 32'hFFFF_FFFC);

        // single ADDI, then second word on the wrapping instance
        ready_i = 1'b1;
        drive(3'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        cyc();
        valid_i = 1'b0;
        chk("addi_valid", {31'b0, valid_o}, 32'd1);
        chk("addi_inst", inst_o, 32'h0050_0093);
        chk("addi_addr", addr_o, 32'h0);
        chk("addi_err", {31'b0, err_o}, 32'd0);
        chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
        drive(3'd0, 5'd2, 5'd0, 5'd0, 32'hFFFF_FFFF);
        cyc();
        valid_i = 1'b0;
        chk("addim1_inst", inst_o, 32'hFFF0_0113);
        chk("addim1_addr", addr_o, 32'd4);
        chk("wrap_addr1", addr2, 32'h0);
        chk("wrap_inst1", inst2, 32'hFFF0_0113);
        cyc();
        chk("drain_valid", {31'b0, valid_o}, 32'd0);

        // SW, BEQ, SRAI streamed back to back
        do_reset();
        drive(3'd3, 5'd0, 5'd0, 5'd2, 32'd8);
        cyc();
        chk("sw_inst", inst_o, 32'h0020_2423);
        chk("sw_addr", addr_o, 32'd0);
        drive(3'd4, 5'd0, 5'd1, 5'd2, -32'sd4);
        cyc();
        chk("beq_inst", inst_o, 32'hFE20_8EE3);
        chk("beq_addr", addr_o, 32'd4);
        drive(3'd1, 5'd3, 5'd3, 5'd0, 32'd2);
        cyc();
        valid_i = 1'b0;
        chk("srai_inst", inst_o, 32'h4021_D193);
        chk("srai_addr", addr_o, 32'd8);
        cyc();
        chk("stream_err", {31'b0, err_o}, 32'd0);

        // immediate boundaries and illegal requests
        do_reset();
        drive(3'd0, 5'd1, 5'd0, 5'd0, 32'd4096);
        cyc();
        chk("ill_addi", inst_o, 32'h0000_0013);
        chk("ill_err", {31'b0, err_o}, 32'd1);
        drive(3'd4, 5'd0, 5'd1, 5'd2, 32'd3);
        cyc();
        valid_i = 1'b0;
        chk("ill_beq", inst_o, 32'h0000_0013);
        chk("ill_cnt2", {24'b0, err_cnt_o}, 32'd2);
        drive(3'd0, 5'd1, 5'd0, 5'd0, 32'd2047);
        cyc();
        chk("addi_max", inst_o, 32'h7FF0_0093);
        drive(3'd0, 5'd1, 5'd0, 5'd0, -32'sd2048);
        cyc();
        chk("addi_min", inst_o, 32'h8000_0093);
        drive(3'd1, 5'd1, 5'd1, 5'd0, 32'd32);
        cyc();
        chk("ill_srai", inst_o, 32'h0000_0013);
        drive(3'd5, 5'd1, 5'd1, 5'd1, 32'd0);
        cyc();
        valid_i = 1'b0;
        chk("ill_kind", inst_o, 32'h0000_0013);
        chk("ill_cnt4", {24'b0, err_cnt_o}, 32'd4);
        chk("nop_addr", addr_o, 32'd20);
        drive(3'd4, 5'd0, 5'd0, 5'd0, -32'sd4096);
        cyc();
        valid_i = 1'b0;
        chk("beq_min", inst_o, 32'h8000_0063);
        chk("beq_cnt", {24'b0, err_cnt_o}, 32'd4);

        // backpressure: two fill the FIFO, third held
        do_reset();
        ready_i = 1'b0;
        drive(3'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        cyc();
        chk("bp_ready1", {31'b0, ready_o}, 32'd1);
        drive(3'd0, 5'd2, 5'd0, 5'd0, 32'd1);
        cyc();
        chk("bp_full", {31'b0, ready_o}, 32'd0);
        drive(3'd0, 5'd3, 5'd0, 5'd0, 32'd2);
        cyc();
        chk("bp_held", {31'b0, ready_o}, 32'd0);
        chk("bp_stable", inst_o, 32'h0050_0093);
        chk("bp_addr", addr_o, 32'd0);
        ready_i = 1'b1;
        cyc();
        chk("bp_w1", inst_o, 32'h0010_0113);
        chk("bp_a1", addr_o, 32'd4);
        cyc();
        valid_i = 1'b0;
        chk("bp_w2", inst_o, 32'h0020_0193);
        chk("bp_a2", addr_o, 32'd8);
        cyc();
        chk("bp_empty", {31'b0, valid_o}, 32'd0);

        // asynchronous reset with a full buffer and err set
        do_reset();
        ready_i = 1'b0;
        drive(3'd0, 5'd1, 5'd0, 5'd0, 32'd4096);
        cyc();
        drive(3'd0, 5'd1, 5'd0, 5'd0, 32'd1);
        cyc();
        valid_i = 1'b0;
        chk("ar_full", {31'b0, ready_o}, 32'd0);
        chk("ar_err1", {31'b0, err_o}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", {31'b0, valid_o}, 32'd0);
        chk("ar_ready", {31'b0, ready_o}, 32'd1);
        chk("ar_err", {31'b0, err_o}, 32'd0);
        chk("ar_addr", addr_o, 32'd0);
        chk("ar_inst", inst_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ready_i = 1'b1;
`ifdef INST_ENCODER_ROUNDTRIP_CHECK_EN
        chk("rt_chk", {31'b0, chk1}, 32'd0);
`endif
        cyc();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
